cpu_datapath: RTL and testbench
===============================

CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 The block SHALL have no parameters; word width is fixed at 8 bits by the shared package type word.
REQ-002 The port clk SHALL be an input, 1 bit wide, used as the clock; all state updates occur on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, providing a synchronous, active-high reset.
REQ-004 The port rs SHALL be an input of type e_reg (2 bits), giving read port 1 address and the register write address.
REQ-005 The port rt SHALL be an input of type e_reg (2 bits), giving the read port 2 address.
REQ-006 The port imm SHALL be an input, 8 bits wide, carrying the immediate operand and the jump target.
REQ-007 The port alu_op SHALL be an input of type e_alu_op (4 bits), selecting the ALU operation.
REQ-008 The port reg_wr SHALL be an input, 1 bit wide, acting as the register write enable.
REQ-009 The port pc_src SHALL be an input, 1 bit wide: 1 selects imm as the next PC.
REQ-010 The port alu_src SHALL be an input, 1 bit wide: 1 selects imm as ALU operand B and a PC step of 2.
REQ-011 The port mem_to_reg SHALL be an input, 1 bit wide: 1 selects mem_data as the write-back value, 0 selects alu_out.
REQ-012 The port mem_data SHALL be an input, 8 bits wide, carrying memory read data.
REQ-013 The port pc SHALL be an output, 8 bits wide, registered, holding the program counter.
REQ-014 The port alu_out SHALL be an output, 8 bits wide, combinational, carrying the ALU result.
REQ-015 The port alu_zero SHALL be an output, 1 bit wide, combinational, equal to 1 when alu_out == 8'h00.
REQ-016 The port mem_wr_data SHALL be an output, 8 bits wide, combinational, equal to the register-file data read at address rt.

Function
REQ-017 The register file SHALL hold 4 x 8-bit registers (RegA=0, RegB=1, RegC=2, RegD=3), with two combinational read ports: d1 = R[rs] and d2 = R[rt].
REQ-018 On a clk rising edge with reg_wr=1 and rst=0, R[rs] SHALL be loaded with mem_to_reg ? mem_data : alu_out.
REQ-019 There SHALL be no write-to-read bypass: a read during a write returns the old value, and the new value is visible from the next cycle.
REQ-020 ALU operand A SHALL be d1, and ALU operand B SHALL be alu_src ? imm : d2.
REQ-021 The ALU ops SHALL be: NOP=0 (out=A), ADD=1 (A+B), SUB=2 (A-B), AND=3, OR=4, XOR=5, NOT=6 (~A), SHL=7 (A<<1), SHR=8 (A>>1, logical), PASSB=9 (out=B).
REQ-022 Any undefined alu_op code SHALL produce out = 8'h00.
REQ-023 All ALU arithmetic SHALL be modulo 2^8; carry and borrow are discarded.
REQ-024 On each clk rising edge with rst=0, pc SHALL be loaded with pc_src ? imm : (pc + (alu_src ? 2 : 1)), modulo 256, so 8'hFF+1 wraps to 8'h00 and 8'hFF+2 wraps to 8'h01.
REQ-025 When pc_src=1, the jump to imm SHALL take priority over the increment, regardless of alu_src.

Reset
REQ-026 While rst=1 at a clk rising edge, pc SHALL become 8'h00 and all four registers SHALL become 8'h00.
REQ-027 Reset SHALL override reg_wr, so no register write occurs in a reset cycle.
REQ-028 After reset, alu_out SHALL follow the zeroed registers (for example, NOP with rs=RegA gives 8'h00 and alu_zero=1).
REQ-029 Reset asserted mid-operation SHALL take effect at the next rising edge with no partial write.

Structure
REQ-030 The shared package SHALL contain the word typedef (8 bits), the e_reg enum (2 bits) and the e_alu_op enum (4 bits, with the encodings of REQ-021).
REQ-031 The block SHALL be built from two sub-modules, reg_file (storage plus read/write ports) and alu (combinational result plus zero flag).
REQ-032 The muxes and the PC register SHALL reside in cpu_datapath.

Verification
REQ-033 Register write/read: with rst released and reg_wr=1, mem_to_reg=1, write 7A to A, 8A to B, 9A to C and FD to D; then with reg_wr=0, alu_op=NOP and rs=A..D, alu_out SHALL read 7A, 8A, 9A, FD in turn.
REQ-034 ALU operations: with A=7A, B=8A, alu_src=0, rs=A, rt=B, ADD SHALL give 04, SUB SHALL give F0, XOR SHALL give F0, and AND SHALL give 0A.
REQ-035 Zero flag: with rs=rt=A and SUB, alu_out SHALL be 00 and alu_zero SHALL be 1.
REQ-036 Immediate operand: with alu_src=1, imm=05, rs=A and ADD, alu_out SHALL be 7F.
REQ-037 PC sequencing: from reset (pc=00), three cycles with alu_src=0 SHALL give pc 01, 02, 03; one cycle with alu_src=1 SHALL give 05; pc_src=1 with imm=F0 SHALL give F0.
REQ-038 PC wrap and reset: from pc=FF with alu_src=1 the next pc SHALL be 01; asserting rst while reg_wr=1 SHALL give pc 00 and all registers 00.

Source files
------------

// File: rtl/cpu_datapath_pkg.sv
// Shared types for the 8-bit datapath: word, register names and ALU opcodes.
package cpu_datapath_pkg;

  typedef logic [7:0] word;

  typedef enum logic [1:0] {
    RegA = 2'd0,
    RegB = 2'd1,
    RegC = 2'd2,
    RegD = 2'd3
  } e_reg;

  typedef enum logic [3:0] {
    ALU_NOP   = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_NOT   = 4'd6,
    ALU_SHL   = 4'd7,
    ALU_SHR   = 4'd8,
    ALU_PASSB = 4'd9
  } e_alu_op;

  localparam int NUM_REGS = 4;

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational 8-bit ALU; unknown opcodes yield zero.
module alu
  import cpu_datapath_pkg::*;
(
  input  e_alu_op op_i,
  input  word     a_i,
  input  word     b_i,
  output word     y_o,
  output logic    zero_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_NOP:   y_o = a_i;
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_OR:    y_o = a_i | b_i;
      ALU_XOR:   y_o = a_i ^ b_i;
      ALU_NOT:   y_o = ~a_i;
      ALU_SHL:   y_o = {a_i[6:0], 1'b0};
      ALU_SHR:   y_o = {1'b0, a_i[7:1]};
      ALU_PASSB: y_o = b_i;
      default:   y_o = '0;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/cpu_datapath_reg_file.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
module reg_file
  import cpu_datapath_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we_i,
  input  e_reg waddr_i,
  input  word  wdata_i,
  input  e_reg raddr1_i,
  input  e_reg raddr2_i,
  output word  rdata1_o,
  output word  rdata2_o
);

  word regs_q [NUM_REGS];

  // Reset wins over write so a reset cycle never leaves a partial update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the stored value only; a same-cycle write shows up next cycle.
  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/cpu_datapath.sv
// Single-cycle datapath: register file, ALU, operand/write-back muxes and PC.
module cpu_datapath
  import cpu_datapath_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  e_reg    rs,
  input  e_reg    rt,
  input  word     imm,
  input  e_alu_op alu_op,
  input  logic    reg_wr,
  input  logic    pc_src,
  input  logic    alu_src,
  input  logic    mem_to_reg,
  input  word     mem_data,
  output word     pc,
  output word     alu_out,
  output logic    alu_zero,
  output word     mem_wr_data
);

  word d1, d2, opb, wb;
  word pc_q, pc_d;

  assign opb = alu_src ? imm : d2;
  assign wb  = mem_to_reg ? mem_data : alu_out;

  reg_file u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (reg_wr),
    .waddr_i  (rs),
    .wdata_i  (wb),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (d1),
    .rdata2_o (d2)
  );

  alu u_alu (
    .op_i   (alu_op),
    .a_i    (d1),
    .b_i    (opb),
    .y_o    (alu_out),
    .zero_o (alu_zero)
  );

  // Jump beats increment; immediate-form instructions occupy two bytes.
  always_comb begin
    pc_d = pc_q + (alu_src ? 8'd2 : 8'd1);
    if (pc_src) pc_d = imm;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc          = pc_q;
  assign mem_wr_data = d2;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized run vs. reference model.
module tb_cpu_datapath;
  import cpu_datapath_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  e_reg    rs, rt;
  word     imm;
  e_alu_op alu_op;
  logic    reg_wr, pc_src, alu_src, mem_to_reg;
  word     mem_data;
  word     pc, alu_out, mem_wr_data;
  logic    alu_zero;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_r [4];
  int m_pc;

  cpu_datapath dut (
    .clk         (clk),
    .rst         (rst),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .alu_op      (alu_op),
    .reg_wr      (reg_wr),
    .pc_src      (pc_src),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .mem_data    (mem_data),
    .pc          (pc),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .mem_wr_data (mem_wr_data)
  );

  always #5 clk = ~clk;

  function automatic int ref_alu(int op, int a, int b);
    case (op)
      0: return a;
      1: return (a + b) % 256;
      2: return (a - b + 256) % 256;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return 255 - a;
      7: return (a * 2) % 256;
      8: return a / 2;
      9: return b;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_out();
    return ref_alu(int'(alu_op), m_r[int'(rs)], alu_src ? int'(imm) : m_r[int'(rt)]);
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    int wb, wa;
    wb = mem_to_reg ? int'(mem_data) : exp_out();
    wa = int'(rs);
    @(posedge clk); #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_pc = 0;
    end else begin
      if (reg_wr) m_r[wa] = wb;
      m_pc = pc_src ? int'(imm) : (m_pc + (alu_src ? 2 : 1)) % 256;
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; rs = RegA; rt = RegA; imm = 8'h00; alu_op = ALU_NOP;
    reg_wr = 1'b0; pc_src = 1'b0; alu_src = 1'b0; mem_to_reg = 1'b0; mem_data = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; reg_wr = 1'b1; mem_to_reg = 1'b1; mem_data = 8'hA5;
    tick(); tick();
    idle_inputs();
    #1;
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", pc); end
    for (int r = 0; r < 4; r++) begin
      rs = e_reg'(r); rt = e_reg'(r); #1;
      checks++;
      if (alu_out !== 8'h00 || alu_zero !== 1'b1) begin
        errors++; $display("FAIL reset_reg%0d got %h z=%b want 00 z=1", r, alu_out, alu_zero);
      end
      checks++;
      if (mem_wr_data !== 8'h00) begin
        errors++; $display("FAIL reset_d2_reg%0d got %h want 00", r, mem_wr_data);
      end
    end
  endtask

  task automatic test_regwrite();
    word vals [4];
    vals[0] = 8'h7A; vals[1] = 8'h8A; vals[2] = 8'h9A; vals[3] = 8'hFD;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      rs = e_reg'(i); reg_wr = 1'b1; mem_to_reg = 1'b1; mem_data = vals[i];
      tick();
    end
    idle_inputs();
    checks++;
    if (pc !== 8'h04) begin errors++; $display("FAIL regwrite_pc got %h want 04", pc); end
    for (int i = 0; i < 4; i++) begin
      rs = e_reg'(i); rt = e_reg'(i); #1;
      checks++;
      if (alu_out !== vals[i]) begin errors++; $display("FAIL regread_%0d got %h want %h", i, alu_out, vals[i]); end
      checks++;
      if (mem_wr_data !== vals[i]) begin errors++; $display("FAIL d2read_%0d got %h want %h", i, mem_wr_data, vals[i]); end
    end
  endtask

  task automatic test_alu();
    e_alu_op ops [4];
    word     exp [4];
    ops[0] = ALU_ADD; exp[0] = 8'h04;
    ops[1] = ALU_SUB; exp[1] = 8'hF0;
    ops[2] = ALU_XOR; exp[2] = 8'hF0;
    ops[3] = ALU_AND; exp[3] = 8'h0A;
    idle_inputs();
    rs = RegA; rt = RegB;
    for (int i = 0; i < 4; i++) begin
      alu_op = ops[i]; #1;
      checks++;
      if (alu_out !== exp[i] || alu_zero !== 1'b0) begin
        errors++; $display("FAIL alu_op%0d got %h z=%b want %h z=0", int'(ops[i]), alu_out, alu_zero, exp[i]);
      end
    end
    rt = RegA; alu_op = ALU_SUB; #1;
    checks++;
    if (alu_out !== 8'h00 || alu_zero !== 1'b1) begin
      errors++; $display("FAIL alu_zero got %h z=%b want 00 z=1", alu_out, alu_zero);
    end
    alu_src = 1'b1; imm = 8'h05; alu_op = ALU_ADD; #1;
    checks++;
    if (alu_out !== 8'h7F) begin errors++; $display("FAIL alu_imm got %h want 7F", alu_out); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    rs = RegC; reg_wr = 1'b1; alu_op = ALU_ADD; alu_src = 1'b1; imm = 8'h01; #1;
    checks++;
    if (alu_out !== 8'h9B) begin errors++; $display("FAIL b2b_first got %h want 9B", alu_out); end
    tick(); #1;
    checks++;
    if (alu_out !== 8'h9C) begin errors++; $display("FAIL b2b_second got %h want 9C", alu_out); end
    tick();
    reg_wr = 1'b0; alu_op = ALU_NOP; #1;
    checks++;
    if (alu_out !== 8'h9C || int'(alu_out) != m_r[2]) begin
      errors++; $display("FAIL b2b_final got %h want 9C", alu_out);
    end
  endtask

  task automatic test_pc();
    word exp [5];
    idle_inputs();
    rst = 1'b1; tick(); rst = 1'b0;
    exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== exp[i]) begin errors++; $display("FAIL pc_seq%0d got %h want %h", i, pc, exp[i]); end
    end
    alu_src = 1'b1; tick();
    checks++;
    if (pc !== 8'h05) begin errors++; $display("FAIL pc_step2 got %h want 05", pc); end
    pc_src = 1'b1; imm = 8'hF0; tick();
    checks++;
    if (pc !== 8'hF0) begin errors++; $display("FAIL pc_jump got %h want F0", pc); end
    imm = 8'hFF; tick();
    pc_src = 1'b0; alu_src = 1'b1; tick();
    checks++;
    if (pc !== 8'h01) begin errors++; $display("FAIL pc_wrap2 got %h want 01", pc); end
    pc_src = 1'b1; tick();
    pc_src = 1'b0; alu_src = 1'b0; tick();
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL pc_wrap1 got %h want 00", pc); end
    // Load a register, then reset with a write pending
    rs = RegD; reg_wr = 1'b1; mem_to_reg = 1'b1; mem_data = 8'h55; tick();
    rst = 1'b1; mem_data = 8'hAA; tick();
    idle_inputs();
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL rst_mid_pc got %h want 00", pc); end
    for (int r = 0; r < 4; r++) begin
      rs = e_reg'(r); #1;
      checks++;
      if (alu_out !== 8'h00) begin errors++; $display("FAIL rst_mid_reg%0d got %h want 00", r, alu_out); end
    end
  endtask

  task automatic test_random();
    int exp_y;
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 31) == 0);
      rs         = e_reg'($urandom_range(0, 3));
      rt         = e_reg'($urandom_range(0, 3));
      imm        = word'($urandom_range(0, 255));
      alu_op     = e_alu_op'($urandom_range(0, 15));
      reg_wr     = $urandom_range(0, 1) == 1;
      pc_src     = ($urandom_range(0, 7) == 0);
      alu_src    = $urandom_range(0, 1) == 1;
      mem_to_reg = $urandom_range(0, 1) == 1;
      mem_data   = word'($urandom_range(0, 255));
      #1;
      exp_y = exp_out();
      checks++;
      if (int'(alu_out) != exp_y || alu_zero !== (exp_y == 0)) begin
        errors++; $display("FAIL rand_alu n=%0d op=%0d got %h z=%b want %h", n, int'(alu_op), alu_out, alu_zero, exp_y[7:0]);
      end
      checks++;
      if (int'(mem_wr_data) != m_r[int'(rt)]) begin
        errors++; $display("FAIL rand_d2 n=%0d got %h want %h", n, mem_wr_data, m_r[int'(rt)]);
      end
      tick();
      checks++;
      if (int'(pc) != m_pc) begin errors++; $display("FAIL rand_pc n=%0d got %h want %h", n, pc, m_pc); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_pc = 0;
    idle_inputs();
    #1;
    test_reset();
    test_regwrite();
    test_alu();
    test_back_to_back();
    test_pc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
